// File: rtl/branch_pkg.sv
// Shared branch-resolution types: instruction opcodes, resolver FSM states
// and the prediction-queue entry carried between the queue and the resolver.
package branch_pkg;

    // Queue entries are sized for the widest supported PC; narrower PCs are zero-extended.
    localparam int PC_MAX_SIZE = 32;

    typedef enum logic [6:0] {
        B_FORMAT = 7'b1100011,
        J_FORMAT = 7'b1101111
    } instruction_type_t;

    typedef enum logic {
        RUN,
        RECOVER
    } state_t;

    typedef struct packed {
        logic [PC_MAX_SIZE-1:0] pc;
        logic                   taken;
        logic [PC_MAX_SIZE-1:0] target;
    } pred_entry_t;

endpackage

// File: rtl/pred_queue.sv
// In-flight prediction FIFO: push at tail, pop at head, single-cycle flush.
module pred_queue
    import branch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        push,
    input  pred_entry_t push_entry,
    input  logic        pop,
    input  logic        flush,
    output logic        full,
    output logic        empty,
    output pred_entry_t head
);

    localparam int PTR_W = $clog2(DEPTH);

    pred_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full    = (count == (PTR_W + 1)'(DEPTH));
        empty   = (count == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;
        head    = mem[rd_ptr];
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push && !flush) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/branch_resolver.sv
// Compares EX-stage branch outcomes against queued predictions and drives recovery.
// Optional macro BRANCH_RESOLVER_STATS_EN adds saturating branch/mispredict counters.
module branch_resolver
    import branch_pkg::*;
#(
    parameter int PC_SIZE = 12,
    parameter int DEPTH   = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               pred_valid,
    input  logic [PC_SIZE-1:0] pred_pc,
    input  logic               pred_taken,
    input  logic [PC_SIZE-1:0] pred_target,
    output logic               pred_ready,
    input  logic               ex_valid,
    input  logic [6:0]         ex_opcode,
    input  logic [PC_SIZE-1:0] ex_pc,
    input  logic               ex_taken,
    input  logic [PC_SIZE-1:0] ex_target,
    input  logic [PC_SIZE-1:0] ex_next_pc,
    output logic               should_have_jumped,
    output logic               mispredict,
    output logic [PC_SIZE-1:0] redirect_pc,
    output logic               flush_if,
    output logic               flush_id,
    output logic               upd_valid,
    output logic [PC_SIZE-1:0] upd_pc,
    output logic               upd_taken,
    output logic               overflow
`ifdef BRANCH_RESOLVER_STATS_EN
    ,
    output logic [15:0]        branch_count,
    output logic [15:0]        mispredict_count
`endif
);

    state_t      state;
    state_t      state_next;
    logic        q_full;
    logic        q_empty;
    pred_entry_t head;
    pred_entry_t push_entry;
    pred_entry_t pred_used;
    logic        resolve;
    logic        actual_taken;
    logic        mispredict_now;
    logic        push_ok;

    // An empty queue resolves against the default "not taken, fall through" guess.
    always_comb begin
        resolve      = (state == RUN) && ex_valid &&
                       (ex_opcode == B_FORMAT || ex_opcode == J_FORMAT);
        actual_taken = (ex_opcode == J_FORMAT) || ex_taken;
        if (q_empty) begin
            pred_used = '{pc: PC_MAX_SIZE'(ex_pc), taken: 1'b0, target: PC_MAX_SIZE'(ex_next_pc)};
        end else begin
            pred_used = head;
        end
        mispredict_now = resolve &&
                         ((pred_used.pc != PC_MAX_SIZE'(ex_pc)) ||
                          (pred_used.taken != actual_taken) ||
                          (pred_used.taken && actual_taken &&
                           pred_used.target != PC_MAX_SIZE'(ex_target)));
        pred_ready = (state == RUN) && !q_full;
        push_ok    = pred_valid && pred_ready && !mispredict_now;
        push_entry = '{pc: PC_MAX_SIZE'(pred_pc), taken: pred_taken,
                       target: PC_MAX_SIZE'(pred_target)};
    end

    pred_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .CLK       (CLK),
        .RESET     (RESET),
        .push      (push_ok),
        .push_entry(push_entry),
        .pop       (resolve),
        .flush     (mispredict_now),
        .full      (q_full),
        .empty     (q_empty),
        .head      (head)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= RUN;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (mispredict_now) state_next = RECOVER;
            RECOVER: state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Pulses last one cycle; redirect_pc and upd_pc keep their last value between events.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            should_have_jumped <= 1'b0;
            mispredict         <= 1'b0;
            redirect_pc        <= '0;
            flush_if           <= 1'b0;
            flush_id           <= 1'b0;
            upd_valid          <= 1'b0;
            upd_pc             <= '0;
            upd_taken          <= 1'b0;
            overflow           <= 1'b0;
        end else begin
            should_have_jumped <= resolve && actual_taken;
            mispredict         <= mispredict_now;
            flush_if           <= mispredict_now;
            flush_id           <= mispredict_now;
            upd_valid          <= resolve;
            upd_taken          <= resolve && actual_taken;
            if (resolve) upd_pc <= ex_pc;
            if (mispredict_now) redirect_pc <= actual_taken ? ex_target : ex_next_pc;
            if (pred_valid && q_full) overflow <= 1'b1;
        end
    end

`ifdef BRANCH_RESOLVER_STATS_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (resolve && branch_count != 16'hFFFF)
                branch_count <= branch_count + 16'd1;
            if (mispredict_now && mispredict_count != 16'hFFFF)
                mispredict_count <= mispredict_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_branch_resolver;
    import branch_pkg::*;

    localparam int PC_SIZE = 12;
    localparam int DEPTH   = 4;

    logic               CLK;
    logic               RESET;
    logic               pred_valid;
    logic [PC_SIZE-1:0] pred_pc;
    logic               pred_taken;
    logic [PC_SIZE-1:0] pred_target;
    logic               pred_ready;
    logic               ex_valid;
    logic [6:0]         ex_opcode;
    logic [PC_SIZE-1:0] ex_pc;
    logic               ex_taken;
    logic [PC_SIZE-1:0] ex_target;
    logic [PC_SIZE-1:0] ex_next_pc;
    logic               should_have_jumped;
    logic               mispredict;
    logic [PC_SIZE-1:0] redirect_pc;
    logic               flush_if;
    logic               flush_id;
    logic               upd_valid;
    logic [PC_SIZE-1:0] upd_pc;
    logic               upd_taken;
    logic               overflow;
`ifdef BRANCH_RESOLVER_STATS_EN
    logic [15:0]        branch_count;
    logic [15:0]        mispredict_count;
`endif

    branch_resolver #(
        .PC_SIZE(PC_SIZE),
        .DEPTH  (DEPTH)
    ) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .pred_valid        (pred_valid),
        .pred_pc           (pred_pc),
        .pred_taken        (pred_taken),
        .pred_target       (pred_target),
        .pred_ready        (pred_ready),
        .ex_valid          (ex_valid),
        .ex_opcode         (ex_opcode),
        .ex_pc             (ex_pc),
        .ex_taken          (ex_taken),
        .ex_target         (ex_target),
        .ex_next_pc        (ex_next_pc),
        .should_have_jumped(should_have_jumped),
        .mispredict        (mispredict),
        .redirect_pc       (redirect_pc),
        .flush_if          (flush_if),
        .flush_id          (flush_id),
        .upd_valid         (upd_valid),
        .upd_pc            (upd_pc),
        .upd_taken         (upd_taken),
        .overflow          (overflow)
`ifdef BRANCH_RESOLVER_STATS_EN
        ,
        .branch_count      (branch_count),
        .mispredict_count  (mispredict_count)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic [PC_SIZE-1:0] pc;
        logic               taken;
        logic [PC_SIZE-1:0] target;
    } ent_t;

    ent_t               mq[$];
    logic               m_recover;
    logic               e_shj, e_mis, e_upd_valid, e_upd_taken, e_ovf;
    logic [PC_SIZE-1:0] e_redir, e_upd_pc;
    int                 m_bc, m_mc;
    int                 total = 0;
    int                 bad   = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_recover   = 1'b0;
        e_shj       = 1'b0;
        e_mis       = 1'b0;
        e_upd_valid = 1'b0;
        e_upd_taken = 1'b0;
        e_ovf       = 1'b0;
        e_redir     = '0;
        e_upd_pc    = '0;
        m_bc        = 0;
        m_mc        = 0;
    endtask

    // Reference behaviour for one clock edge, from the architectural rules.
    task automatic model_step();
        bit   full, res, actual, mis, push;
        ent_t h;
        e_shj = 0; e_mis = 0; e_upd_valid = 0; e_upd_taken = 0;
        if (m_recover) begin
            m_recover = 0;
            return;
        end
        full = (mq.size() == DEPTH);
        if (pred_valid && full) e_ovf = 1;
        res = ex_valid && (ex_opcode == B_FORMAT || ex_opcode == J_FORMAT);
        mis = 0;
        if (res) begin
            actual = (ex_opcode == J_FORMAT) || ex_taken;
            if (mq.size() > 0) h = mq.pop_front();
            else h = '{pc: ex_pc, taken: 1'b0, target: ex_next_pc};
            mis = (h.pc != ex_pc) || (h.taken != actual) ||
                  (h.taken && actual && h.target != ex_target);
            e_upd_valid = 1;
            e_upd_pc    = ex_pc;
            e_upd_taken = actual;
            e_shj       = actual;
            if (m_bc < 65535) m_bc++;
            if (mis) begin
                e_mis   = 1;
                e_redir = actual ? ex_target : ex_next_pc;
                if (m_mc < 65535) m_mc++;
                mq.delete();
                m_recover = 1;
            end
        end
        push = pred_valid && !full && !mis;
        if (push) mq.push_back('{pc: pred_pc, taken: pred_taken, target: pred_target});
    endtask

    initial forever begin
        @(posedge CLK);
        if (!RESET) model_step();
    end

    initial forever begin
        @(negedge CLK);
        check_output("should_have_jumped", 32'(should_have_jumped), 32'(e_shj));
        check_output("mispredict", 32'(mispredict), 32'(e_mis));
        check_output("flush_if", 32'(flush_if), 32'(e_mis));
        check_output("flush_id", 32'(flush_id), 32'(e_mis));
        check_output("redirect_pc", 32'(redirect_pc), 32'(e_redir));
        check_output("upd_valid", 32'(upd_valid), 32'(e_upd_valid));
        check_output("upd_pc", 32'(upd_pc), 32'(e_upd_pc));
        check_output("upd_taken", 32'(upd_taken), 32'(e_upd_taken));
        check_output("overflow", 32'(overflow), 32'(e_ovf));
        check_output("pred_ready", 32'(pred_ready), 32'(!m_recover && mq.size() < DEPTH));
`ifdef BRANCH_RESOLVER_STATS_EN
        check_output("branch_count", 32'(branch_count), 32'(m_bc));
        check_output("mispredict_count", 32'(mispredict_count), 32'(m_mc));
`endif
    end

    task automatic set_idle();
        pred_valid = 0; pred_pc = '0; pred_taken = 0; pred_target = '0;
        ex_valid = 0; ex_opcode = '0; ex_pc = '0; ex_taken = 0; ex_target = '0; ex_next_pc = '0;
    endtask

    task automatic begin_cycle();
        @(negedge CLK);
        #2;
    endtask

    task automatic apply_stimulus();
        @(posedge CLK);
        #1;
        set_idle();
    endtask

    task automatic set_push(input logic [PC_SIZE-1:0] pc, input logic tk, input logic [PC_SIZE-1:0] tg);
        pred_valid = 1; pred_pc = pc; pred_taken = tk; pred_target = tg;
    endtask

    task automatic set_resolve(input logic [6:0] op, input logic [PC_SIZE-1:0] pc, input logic tk,
                               input logic [PC_SIZE-1:0] tg, input logic [PC_SIZE-1:0] nx);
        ex_valid = 1; ex_opcode = op; ex_pc = pc; ex_taken = tk; ex_target = tg; ex_next_pc = nx;
    endtask

    task automatic idle_cycle();
        begin_cycle();
        apply_stimulus();
    endtask

    // Async reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        #3;
        RESET = 1;
        model_reset();
        #1;
        check_output("rst_pred_ready", 32'(pred_ready), 32'h1);
        check_output("rst_mispredict", 32'(mispredict), 32'h0);
        check_output("rst_flush_if", 32'(flush_if), 32'h0);
        check_output("rst_upd_valid", 32'(upd_valid), 32'h0);
        check_output("rst_overflow", 32'(overflow), 32'h0);
        check_output("rst_redirect_pc", 32'(redirect_pc), 32'h0);
        check_output("rst_upd_pc", 32'(upd_pc), 32'h0);
`ifdef BRANCH_RESOLVER_STATS_EN
        check_output("rst_branch_count", 32'(branch_count), 32'h0);
        check_output("rst_mispredict_count", 32'(mispredict_count), 32'h0);
`endif
        @(negedge CLK);
        #2;
        RESET = 0;
    endtask

    initial begin
        int sel;
        RESET = 1;
        set_idle();
        model_reset();
        repeat (2) @(negedge CLK);
        check_output("init_pred_ready", 32'(pred_ready), 32'h1);
        check_output("init_overflow", 32'(overflow), 32'h0);
        #2;
        RESET = 0;

        // Correctly predicted taken branch.
        begin_cycle(); set_push(12'h040, 1, 12'h080); apply_stimulus();
        begin_cycle(); set_resolve(B_FORMAT, 12'h040, 1, 12'h080, 12'h044); apply_stimulus();
        check_output("hit_upd_valid", 32'(upd_valid), 32'h1);
        check_output("hit_upd_taken", 32'(upd_taken), 32'h1);
        check_output("hit_upd_pc", 32'(upd_pc), 32'h040);
        check_output("hit_mispredict", 32'(mispredict), 32'h0);
        check_output("hit_flush_if", 32'(flush_if), 32'h0);

        // Direction mispredict, then one RECOVER cycle.
        begin_cycle(); set_push(12'h040, 0, 12'h044); apply_stimulus();
        begin_cycle(); set_resolve(B_FORMAT, 12'h040, 1, 12'h100, 12'h044); apply_stimulus();
        check_output("dir_mispredict", 32'(mispredict), 32'h1);
        check_output("dir_flush_if", 32'(flush_if), 32'h1);
        check_output("dir_flush_id", 32'(flush_id), 32'h1);
        check_output("dir_redirect_pc", 32'(redirect_pc), 32'h100);
        check_output("recover_pred_ready", 32'(pred_ready), 32'h0);
        idle_cycle();
        check_output("run_pred_ready", 32'(pred_ready), 32'h1);
        check_output("pulse_cleared", 32'(mispredict), 32'h0);

        // Jump with empty queue and ex_taken low.
        begin_cycle(); set_resolve(J_FORMAT, 12'h010, 0, 12'h200, 12'h014); apply_stimulus();
        check_output("jmp_mispredict", 32'(mispredict), 32'h1);
        check_output("jmp_should_have_jumped", 32'(should_have_jumped), 32'h1);
        check_output("jmp_redirect_pc", 32'(redirect_pc), 32'h200);
        idle_cycle();

        // Fill the queue, overflow on the fifth push, drain in order.
        for (int i = 0; i < 5; i++) begin
            begin_cycle(); set_push(12'(12'h100 + 4 * i), 0, 12'h000); apply_stimulus();
            if (i == 3) check_output("full_pred_ready", 32'(pred_ready), 32'h0);
        end
        check_output("ovf_overflow", 32'(overflow), 32'h1);
        for (int i = 0; i < 4; i++) begin
            begin_cycle();
            set_resolve(B_FORMAT, 12'(12'h100 + 4 * i), 0, 12'h000, 12'(12'h104 + 4 * i));
            apply_stimulus();
            check_output("drain_mispredict", 32'(mispredict), 32'h0);
            check_output("drain_upd_pc", 32'(upd_pc), 32'(12'h100 + 4 * i));
        end
        check_output("drained_pred_ready", 32'(pred_ready), 32'h1);
        check_output("ovf_sticky", 32'(overflow), 32'h1);

        // Wrong-path push in the mispredict cycle is discarded.
        begin_cycle(); set_push(12'h0A0, 0, 12'h000); apply_stimulus();
        begin_cycle();
        set_push(12'h0C0, 1, 12'h0D0);
        set_resolve(B_FORMAT, 12'h0A0, 1, 12'h300, 12'h0A4);
        apply_stimulus();
        check_output("wp_mispredict", 32'(mispredict), 32'h1);
        check_output("wp_redirect_pc", 32'(redirect_pc), 32'h300);
        idle_cycle();
        begin_cycle(); set_resolve(B_FORMAT, 12'h0C0, 0, 12'h000, 12'h0C4); apply_stimulus();
        check_output("wp_default_mispredict", 32'(mispredict), 32'h0);
        check_output("wp_default_upd_taken", 32'(upd_taken), 32'h0);

        // Reset with three queued entries discards them.
        for (int i = 0; i < 3; i++) begin
            begin_cycle(); set_push(12'(12'h200 + 4 * i), 1, 12'h3F0); apply_stimulus();
        end
        do_reset();
        begin_cycle(); set_resolve(B_FORMAT, 12'h300, 0, 12'h000, 12'h304); apply_stimulus();
        check_output("post_rst_mispredict", 32'(mispredict), 32'h0);

        // Reset during RECOVER returns to RUN immediately.
        begin_cycle(); set_push(12'h020, 0, 12'h000); apply_stimulus();
        begin_cycle(); set_resolve(B_FORMAT, 12'h024, 0, 12'h000, 12'h028); apply_stimulus();
        check_output("pre_rst_mispredict", 32'(mispredict), 32'h1);
        do_reset();

        // Random traffic against the reference model.
        for (int n = 0; n < 2000; n++) begin
            begin_cycle();
            pred_valid  = ($urandom_range(0, 9) < 5);
            pred_pc     = 12'($urandom);
            pred_taken  = 1'($urandom);
            pred_target = 12'($urandom);
            ex_valid    = ($urandom_range(0, 9) < 4);
            sel = int'($urandom_range(0, 3));
            ex_opcode = (sel < 2) ? B_FORMAT : (sel == 2) ? J_FORMAT : 7'h33;
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
                ex_pc     = mq[0].pc;
                ex_taken  = mq[0].taken;
                ex_target = ($urandom_range(0, 7) == 0) ? 12'($urandom) : mq[0].target;
            end else begin
                ex_pc     = 12'($urandom);
                ex_taken  = 1'($urandom);
                ex_target = 12'($urandom);
            end
            ex_next_pc = ex_pc + 12'd4;
            apply_stimulus();
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        repeat (2) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have parameter PC_SIZE, default 12, PC/target width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, in-flight prediction queue entries (power of two, >=2).
REQ-003 SHALL have ports: CLK in 1 clock; RESET in 1 async active-high reset (one clock; reset asynchronous, active-high).
REQ-004 SHALL have ports: pred_valid in 1 prediction push; pred_pc in PC_SIZE predicted-branch PC; pred_taken in 1 predicted direction; pred_target in PC_SIZE predicted target; pred_ready out 1 queue not full.
REQ-005 SHALL have ports: ex_valid in 1 instruction resolving in EX; ex_opcode in 7 its opcode; ex_pc in PC_SIZE its PC; ex_taken in 1 actual direction; ex_target in PC_SIZE actual target; ex_next_pc in PC_SIZE fall-through PC.
REQ-006 SHALL have ports: should_have_jumped out 1; mispredict out 1; redirect_pc out PC_SIZE; flush_if out 1; flush_id out 1; upd_valid out 1; upd_pc out PC_SIZE; upd_taken out 1; overflow out 1 sticky.

Function
REQ-007 Resolve only when ex_valid and ex_opcode is B_FORMAT or J_FORMAT; J_FORMAT SHALL always count as taken regardless of ex_taken.
REQ-008 Push on pred_valid && pred_ready; resolve pops the head; push and pop in the same cycle both occur, count unchanged.
REQ-009 pred_valid while full SHALL be dropped and set overflow (sticky until RESET).
REQ-010 Resolve with empty queue SHALL use the default prediction: not taken, target ex_next_pc.
REQ-011 Mispredict when any holds: head pc != ex_pc; predicted direction != actual; both taken and pred_target != ex_target.
REQ-012 All outputs except pred_ready SHALL be registered: valid the cycle after resolve, 1-cycle pulses.
REQ-013 should_have_jumped SHALL equal the resolved actual direction; upd_valid/upd_pc/upd_taken SHALL pulse on every resolve (ex_pc, actual direction).
REQ-014 On mispredict: mispredict=flush_if=flush_id=1; redirect_pc = ex_target if actual taken else ex_next_pc; otherwise redirect_pc holds its last value.
REQ-015 FSM states RUN, RECOVER; RUN->RECOVER on mispredict resolve; RECOVER->RUN after exactly 1 cycle.
REQ-016 On mispredict resolve the whole queue SHALL be emptied, and any same-cycle push discarded (wrong path).
REQ-017 In RECOVER pushes SHALL be discarded, pred_ready=0, and ex_valid ignored.
REQ-018 Pointers wrap modulo DEPTH; occupancy counter of width clog2(DEPTH)+1 distinguishes full from empty.

Reset
REQ-019 On RESET: state RUN, queue empty, pred_ready=1, overflow=0, all pulse outputs 0, redirect_pc=0, upd_pc=0; takes effect immediately, mid-operation included, and discards in-flight entries.

Configuration
REQ-020 Macro BRANCH_RESOLVER_STATS_EN SHALL, when defined, add outputs branch_count and mispredict_count (16 bits each), incremented per resolve / per mispredict, saturating at 16'hFFFF, reset to 0.
REQ-021 Without BRANCH_RESOLVER_STATS_EN those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-022 B_FORMAT and J_FORMAT opcodes SHALL come from the shared instruction_type definitions; state enum and queue-entry struct (pc, taken, target) SHALL live in a shared package branch_pkg.
REQ-023 Queue SHALL be a sub-module pred_queue (push/pop/flush, full/empty, head entry); FSM and compare logic in branch_resolver.

Verification
REQ-024 Push {pc=0x040, taken=1, target=0x080}; resolve B_FORMAT pc=0x040 taken=1 target=0x080 -> next cycle upd_valid=1, upd_taken=1, mispredict=0, flush_if=0.
REQ-025 Push {0x040, taken=0}; resolve pc=0x040 taken=1 target=0x100 -> mispredict=flush_if=flush_id=1, redirect_pc=0x100, queue empty, one RECOVER cycle with pred_ready=0.
REQ-026 Queue empty; resolve J_FORMAT pc=0x010 target=0x200 next=0x014 with ex_taken=0 -> mispredict, should_have_jumped=1, redirect_pc=0x200.
REQ-027 DEPTH=4: push 5 entries with no resolve -> pred_ready=0 after 4th, 5th dropped, overflow=1; then resolve all 4 in order -> none mispredict.
REQ-028 Mispredict resolve concurrent with push of 0x0C0 -> push discarded; later resolve pc=0x0C0 sees empty queue and uses default not-taken.
REQ-029 Assert RESET mid-RECOVER with 3 queued entries -> immediately RUN, empty, all pulses 0, overflow=0; with BRANCH_RESOLVER_STATS_EN counters =0.
